// File: rtl/result_scoreboard.sv
// In-order result checker: queues expected (value, bit-count) entries and compares each actual result against the oldest one.
// Optional first-mismatch capture is built only when SCOREBOARD_FAIL_CAPTURE_EN is defined.
module result_scoreboard #(
  parameter int WORD   = 64,
  parameter int BITS_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [WORD-1:0]   exp_data,
  input  logic [BITS_W-1:0] exp_bits,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [WORD-1:0]   act_data,
  input  logic [BITS_W-1:0] act_bits,
  output logic [CNT_W-1:0]  step_count,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic              cmp_done,
  output logic              cmp_pass,
  output logic [CNT_W-1:0]  fail_step,
  output logic [WORD-1:0]   fail_exp,
  output logic [WORD-1:0]   fail_act,
  output logic              fail_seen
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [WORD-1:0]   data;
    logic [BITS_W-1:0] bits;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            full, empty, push, pop, match;
  logic [CNT_W-1:0] step_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign exp_ready = !full;
  assign act_ready = !empty;
  assign push      = exp_valid && exp_ready && !clear;
  assign pop       = act_valid && act_ready && !clear;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign match     = (head.data == act_data) && (head.bits == act_bits);
  assign step_inc  = sat_inc(step_count);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{data: exp_data, bits: exp_bits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      step_count <= '0;
      pass_count <= '0;
      fail_count <= '0;
      cmp_done   <= 1'b0;
      cmp_pass   <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      step_count <= '0;
      pass_count <= '0;
      fail_count <= '0;
      cmp_done   <= 1'b0;
      cmp_pass   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      cmp_done <= pop;
      cmp_pass <= pop && match;
      if (pop) begin
        step_count <= step_inc;
        if (match) pass_count <= sat_inc(pass_count);
        else       fail_count <= sat_inc(fail_count);
      end
    end
  end

`ifdef SCOREBOARD_FAIL_CAPTURE_EN
  // fail_step is the 1-based number of the failing compare, i.e. the incremented step count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_step <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
      fail_seen <= 1'b0;
    end else if (clear) begin
      fail_step <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
      fail_seen <= 1'b0;
    end else if (pop && !match && !fail_seen) begin
      fail_step <= step_inc;
      fail_exp  <= head.data;
      fail_act  <= act_data;
      fail_seen <= 1'b1;
    end
  end
`else
  assign fail_step = '0;
  assign fail_exp  = '0;
  assign fail_act  = '0;
  assign fail_seen = 1'b0;
`endif
endmodule

// File: tb/tb_result_scoreboard.sv
// Directed bench for result_scoreboard: a vector table for the basic flow plus hand sequences for full, saturation, clear and reset.
module tb_result_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n, clear;
  logic        exp_valid, exp_ready, act_valid, act_ready;
  logic [63:0] exp_data, act_data;
  logic [7:0]  exp_bits, act_bits;
  logic [3:0]  step_count, pass_count, fail_count, fail_step;
  logic        cmp_done, cmp_pass, fail_seen;
  logic [63:0] fail_exp, fail_act;

  int total = 0;
  int bad   = 0;

`ifdef SCOREBOARD_FAIL_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  result_scoreboard #(.WORD(64), .BITS_W(8), .DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data), .exp_bits(exp_bits),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data), .act_bits(act_bits),
    .step_count(step_count), .pass_count(pass_count), .fail_count(fail_count),
    .cmp_done(cmp_done), .cmp_pass(cmp_pass),
    .fail_step(fail_step), .fail_exp(fail_exp), .fail_act(fail_act), .fail_seen(fail_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ev; logic [63:0] ed; logic [7:0] eb;
    logic av; logic [63:0] ad; logic [7:0] ab;
    logic clr;
    logic xe, xa; int s, p, f; logic d, cp;
  } vec_t;

  vec_t tab[17];

  function automatic vec_t mk(logic ev, logic [63:0] ed, logic [7:0] eb,
                              logic av, logic [63:0] ad, logic [7:0] ab, logic clr,
                              logic xe, logic xa, int s, int p, int f, logic d, logic cp);
    vec_t v;
    v.ev = ev; v.ed = ed; v.eb = eb; v.av = av; v.ad = ad; v.ab = ab; v.clr = clr;
    v.xe = xe; v.xa = xa; v.s = s; v.p = p; v.f = f; v.d = d; v.cp = cp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic chk_counts(input string tag, input int s, input int p, input int f);
    chk({tag, " step"}, 64'(step_count), 64'(s));
    chk({tag, " pass"}, 64'(pass_count), 64'(p));
    chk({tag, " fail"}, 64'(fail_count), 64'(f));
  endtask

  // Apply inputs for one cycle, then observe #1 after the edge and return inputs to idle.
  task automatic cyc(input logic ev, input logic [63:0] ed, input logic [7:0] eb,
                     input logic av, input logic [63:0] ad, input logic [7:0] ab, input logic clr);
    exp_valid = ev; exp_data = ed; exp_bits = eb;
    act_valid = av; act_data = ad; act_bits = ab; clear = clr;
    @(posedge clk); #1;
    exp_valid = 1'b0; act_valid = 1'b0; clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0;
    exp_valid = 1'b0; exp_data = '0; exp_bits = '0;
    act_valid = 1'b0; act_data = '0; act_bits = '0;
    for (int i = 0; i < 5; i++) tab[i] = mk(0, 0, 0, 1, 64'h10, 8, 0, 1, 0, 0, 0, 0, 0, 0);
    tab[5]  = mk(1, 64'h10, 8,  0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    tab[6]  = mk(1, 64'h20, 8,  0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    tab[7]  = mk(1, 64'h30, 8,  0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    tab[8]  = mk(0, 0, 0, 1, 64'h10, 8,  0, 1, 1, 1, 1, 0, 1, 1);
    tab[9]  = mk(0, 0, 0, 1, 64'h20, 8,  0, 1, 1, 2, 2, 0, 1, 1);
    tab[10] = mk(0, 0, 0, 1, 64'h30, 8,  0, 1, 0, 3, 3, 0, 1, 1);
    tab[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 3, 0, 0, 0);
    tab[12] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    tab[13] = mk(1, 64'hAA, 8,  0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    tab[14] = mk(1, 64'hBB, 16, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    tab[15] = mk(0, 0, 0, 1, 64'hAA, 4,  0, 1, 1, 1, 0, 1, 1, 0);
    tab[16] = mk(0, 0, 0, 1, 64'hBC, 16, 0, 1, 0, 2, 0, 2, 1, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst exp_ready", 64'(exp_ready), 1);
    chk("rst act_ready", 64'(act_ready), 0);
    chk_counts("rst", 0, 0, 0);
    chk("rst cmp_done", 64'(cmp_done), 0);
    chk("rst fail_seen", 64'(fail_seen), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      cyc(tab[i].ev, tab[i].ed, tab[i].eb, tab[i].av, tab[i].ad, tab[i].ab, tab[i].clr);
      chk({t, " exp_ready"}, 64'(exp_ready), 64'(tab[i].xe));
      chk({t, " act_ready"}, 64'(act_ready), 64'(tab[i].xa));
      chk_counts(t, tab[i].s, tab[i].p, tab[i].f);
      chk({t, " cmp_done"}, 64'(cmp_done), 64'(tab[i].d));
      if (tab[i].d) chk({t, " cmp_pass"}, 64'(cmp_pass), 64'(tab[i].cp));
    end
    chk("cap fail_step", 64'(fail_step), CAP ? 64'd1 : 64'd0);
    chk("cap fail_exp",  fail_exp, CAP ? 64'hAA : 64'h0);
    chk("cap fail_act",  fail_act, CAP ? 64'hAA : 64'h0);
    chk("cap fail_seen", 64'(fail_seen), 64'(CAP));

    // Fill, refused push while full, push+pop at 7, refill, drain in order
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 64'(i), 8, 0, 0, 0, 0);
    chk("full exp_ready", 64'(exp_ready), 0);
    chk("full act_ready", 64'(act_ready), 1);
    cyc(1, 64'h99, 8, 1, 64'h0, 8, 0);
    chk("full push refused exp_ready", 64'(exp_ready), 1);
    chk_counts("full pop", 1, 1, 0);
    cyc(1, 64'h99, 8, 1, 64'h1, 8, 0);
    chk("pushpop exp_ready", 64'(exp_ready), 1);
    chk("pushpop cmp_done", 64'(cmp_done), 1);
    cyc(1, 64'hA0, 8, 0, 0, 0, 0);
    chk("refill exp_ready", 64'(exp_ready), 0);
    for (int i = 2; i < 8; i++) cyc(0, 0, 0, 1, 64'(i), 8, 0);
    cyc(0, 0, 0, 1, 64'h99, 8, 0);
    cyc(0, 0, 0, 1, 64'hA0, 8, 0);
    chk("drain act_ready", 64'(act_ready), 0);
    chk_counts("drain", 10, 10, 0);

    // Saturation at CNT_W=4
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) begin
      cyc(1, 64'(i + 5), 8, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 64'(i + 5), 8, 0);
    end
    chk_counts("sat", 15, 15, 0);
    cyc(1, 64'h55, 8, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 64'h56, 8, 0);
    chk_counts("sat fail", 15, 15, 1);
    chk("sat fail_step", 64'(fail_step), CAP ? 64'd15 : 64'd0);
    chk("sat fail_act",  fail_act, CAP ? 64'h56 : 64'h0);

    // Clear during an active compare wins
    cyc(1, 64'h77, 8, 0, 0, 0, 0);
    cyc(1, 64'h78, 8, 1, 64'h77, 8, 1);
    chk_counts("clear", 0, 0, 0);
    chk("clear cmp_done", 64'(cmp_done), 0);
    chk("clear act_ready", 64'(act_ready), 0);
    chk("clear exp_ready", 64'(exp_ready), 1);
    chk("clear fail_seen", 64'(fail_seen), 0);

    // Reset mid-stream
    cyc(1, 64'h1, 8, 0, 0, 0, 0);
    cyc(1, 64'h2, 8, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 64'h3, 8, 0);
    chk_counts("pre-rst", 1, 0, 1);
    act_valid = 1'b1; act_data = 64'h2; act_bits = 8;
    #2 rst_n = 1'b0;
    #1;
    chk_counts("mid-rst", 0, 0, 0);
    chk("mid-rst act_ready", 64'(act_ready), 0);
    chk("mid-rst exp_ready", 64'(exp_ready), 1);
    chk("mid-rst fail_seen", 64'(fail_seen), 0);
    @(posedge clk); #1;
    chk("in-rst cmp_done", 64'(cmp_done), 0);
    act_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_counts("post-rst", 0, 0, 0);
    chk("post-rst act_ready", 64'(act_ready), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end
endmodule
